crc_serial_engine: RTL

Parametrised bit-serial CRC engine; the next generation of the fixed 3-bit `crc4_gen`. Width, polynomial and init value are configurable, and data is accepted MSB-first under `wr_en` within `start`/`last` framed packets. After the last data bit, the block appends the computed CRC serially on `ser_out`. An optional compiled-in checker validates received frames that carry a trailing CRC. It sits between a serial data source such as `shift_reg` and the line/serialiser.

---
 rtl/crc_serial_pkg.sv | 13 +
 rtl/crc_serial_engine_crc_lfsr_step.sv | 18 +
 rtl/crc_serial_engine.sv | 113 +++++++++++
 3 files changed

// File: rtl/crc_serial_pkg.sv
// Shared types and polynomial constants for the bit-serial CRC engine.
package crc_serial_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        APPEND = 2'd2
    } crc_state_t;

    localparam logic [2:0] CRC3_POLY = 3'b011;
    localparam logic [7:0] CRC8_POLY = 8'h07;

endpackage

// File: rtl/crc_serial_engine_crc_lfsr_step.sv
// Combinational one-bit CRC update: MSB-first, no reflection, implicit x^CRC_W term.
module crc_lfsr_step
    import crc_serial_pkg::*;
#(
    parameter int               CRC_W = 3,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC3_POLY)
) (
    input  logic [CRC_W-1:0] crc,
    input  logic             data_in,
    output logic [CRC_W-1:0] crc_next
);

    logic fb;

    assign fb       = data_in ^ crc[CRC_W-1];
    assign crc_next = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC generator that appends the CRC MSB-first after each framed packet.
// Optional receive-side checker compiled in with CRC_SERIAL_CHECK_EN.
module crc_serial_engine
    import crc_serial_pkg::*;
#(
    parameter int               CRC_W = 3,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC3_POLY),
    parameter logic [CRC_W-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             wr_en,
    input  logic             data_in,
    input  logic             last,
`ifdef CRC_SERIAL_CHECK_EN
    input  logic             chk,
`endif
    output logic [CRC_W-1:0] crc_word,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
`ifdef CRC_SERIAL_CHECK_EN
    output logic             crc_err,
`endif
    output logic             done
);

    localparam int CNT_W = $clog2(CRC_W + 1);

    crc_state_t       state, state_nxt;
    logic [CRC_W-1:0] crc, crc_step;
    logic [CNT_W-1:0] cnt;
    logic             chk_r;
    logic             accept, last_bit, ser_end;

    // start always wins over a same-cycle data bit
    assign accept   = (state == DATA) & wr_en & ~start;
    assign last_bit = accept & last;
    assign ser_end  = (state == APPEND) & (cnt == CNT_W'(1)) & ~start;

    crc_lfsr_step #(.CRC_W(CRC_W), .POLY(POLY)) u_step (
        .crc      (crc),
        .data_in  (data_in),
        .crc_next (crc_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = DATA;
        end else begin
            case (state)
                DATA:    if (wr_en & last) state_nxt = chk_r ? IDLE : APPEND;
                APPEND:  if (cnt == CNT_W'(1)) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        ser_valid = (state == APPEND);
        busy      = (state != IDLE);
        ser_out   = ser_valid & crc[CRC_W-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc      <= '0;
            cnt      <= '0;
            crc_word <= '0;
            done     <= 1'b0;
        end else begin
            done <= ser_end | (last_bit & chk_r);
            if (start) begin
                crc <= INIT;
                cnt <= '0;
            end else if (accept) begin
                crc <= crc_step;
                if (last) begin
                    crc_word <= crc_step;
                    cnt      <= CNT_W'(CRC_W);
                end
            end else if (state == APPEND) begin
                // unload MSB-first, zero fill behind
                crc <= crc << 1;
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifdef CRC_SERIAL_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_r   <= 1'b0;
            crc_err <= 1'b0;
        end else if (start) begin
            chk_r   <= chk;
            crc_err <= 1'b0;
        end else if (last_bit & chk_r) begin
            crc_err <= |crc_step;
        end
    end
`else
    assign chk_r = 1'b0;
`endif

endmodule
